// File: rtl/drink_pkg.sv
// Shared types and constants for the drink buyer: FSM states, coin choices,
// error codes and coin weights in half-units.
package drink_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INSERT = 2'd1,
    WAIT   = 2'd2,
    FIN    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_HALF = 2'd1,
    COIN_ONE  = 2'd2
  } coin_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_COIN    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CHANGE  = 2'd3;

  localparam int DEFAULT_PRICE_HALVES = 5;
  localparam int HALF_W = 1;
  localparam int ONE_W  = 2;

  function automatic int coin_weight(input coin_t c);
    case (c)
      COIN_HALF: coin_weight = HALF_W;
      COIN_ONE:  coin_weight = ONE_W;
      default:   coin_weight = 0;
    endcase
  endfunction

endpackage

// File: rtl/drink_buyer_coin_sel.sv
// Combinational coin chooser: picks the next coin to insert from the remaining
// stock and preference, or flags that the price can no longer be reached.
module drink_buyer_coin_sel
  import drink_pkg::*;
#(
  parameter int PRICE_HALVES = DEFAULT_PRICE_HALVES,
  parameter int CNT_W        = 3,
  parameter int CRED_W       = 3
) (
  input  logic [CNT_W-1:0]  one_stock,
  input  logic [CNT_W-1:0]  half_stock,
  input  logic              prefer_one,
  input  logic [CRED_W-1:0] credit,
  output coin_t             coin,
  output logic              insufficient
);

  logic pref_avail;
  logic other_avail;

  always_comb begin
    pref_avail   = prefer_one ? (|one_stock) : (|half_stock);
    other_avail  = prefer_one ? (|half_stock) : (|one_stock);
    coin         = COIN_NONE;
    insufficient = 1'b0;
    if (credit >= CRED_W'(PRICE_HALVES)) begin
      coin = COIN_NONE;
    end else if (pref_avail) begin
      coin = prefer_one ? COIN_ONE : COIN_HALF;
    end else if (other_avail) begin
      coin = prefer_one ? COIN_HALF : COIN_ONE;
    end else begin
      insufficient = 1'b1;
    end
  end

endmodule

// File: rtl/drink_buyer.sv
// Customer-side initiator for the vending machine: feeds coins until the price
// is covered, then waits for the dispense and reports drink/change/error status.
module drink_buyer
  import drink_pkg::*;
#(
  parameter int PRICE_HALVES = DEFAULT_PRICE_HALVES,
  parameter int TIMEOUT      = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_one,
  input  logic [CNT_W-1:0] n_half,
  input  logic             prefer_one,
  input  logic             vend_out,
  input  logic             vend_cout,
  output logic             one,
  output logic             half,
  output logic             busy,
  output logic             done,
  output logic             got_drink,
  output logic             got_change,
  output logic [1:0]       err
);

  // Credit can overshoot the price by at most one half-unit (a one-unit coin
  // inserted at PRICE_HALVES-1).
  localparam int CRED_W = $clog2(PRICE_HALVES + 2);
  localparam int TMR_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  one_stock_q, one_stock_d;
  logic [CNT_W-1:0]  half_stock_q, half_stock_d;
  logic              prefer_q, prefer_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              one_q, one_d;
  logic              half_q, half_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              got_drink_q, got_drink_d;
  logic              got_change_q, got_change_d;
  logic [1:0]        err_q, err_d;

  coin_t coin;
  logic  insufficient;
  logic  change_exp;

  drink_buyer_coin_sel #(
    .PRICE_HALVES(PRICE_HALVES),
    .CNT_W       (CNT_W),
    .CRED_W      (CRED_W)
  ) u_coin_sel (
    .one_stock   (one_stock_q),
    .half_stock  (half_stock_q),
    .prefer_one  (prefer_q),
    .credit      (credit_q),
    .coin        (coin),
    .insufficient(insufficient)
  );

  always_comb begin
    state_d      = state_q;
    one_stock_d  = one_stock_q;
    half_stock_d = half_stock_q;
    prefer_d     = prefer_q;
    credit_d     = credit_q;
    timer_d      = timer_q;
    one_d        = 1'b0;
    half_d       = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    got_drink_d  = got_drink_q;
    got_change_d = got_change_q;
    err_d        = err_q;
    change_exp   = (credit_q > CRED_W'(PRICE_HALVES));

    case (state_q)
      IDLE: begin
        if (start) begin
          one_stock_d  = n_one;
          half_stock_d = n_half;
          prefer_d     = prefer_one;
          credit_d     = '0;
          got_drink_d  = 1'b0;
          got_change_d = 1'b0;
          err_d        = ERR_NONE;
          busy_d       = 1'b1;
          state_d      = INSERT;
        end
      end
      INSERT: begin
        if (coin == COIN_ONE) begin
          one_d       = 1'b1;
          one_stock_d = one_stock_q - CNT_W'(1);
          credit_d    = credit_q + CRED_W'(coin_weight(coin));
        end else if (coin == COIN_HALF) begin
          half_d       = 1'b1;
          half_stock_d = half_stock_q - CNT_W'(1);
          credit_d     = credit_q + CRED_W'(coin_weight(coin));
        end else if (insufficient) begin
          err_d   = ERR_COIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          timer_d = TMR_W'(TIMEOUT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (vend_out) begin
          got_drink_d  = 1'b1;
          got_change_d = vend_cout;
          if (vend_cout != change_exp) err_d = ERR_CHANGE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else if (timer_q <= TMR_W'(1)) begin
          err_d   = ERR_TIMEOUT;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      one_stock_q  <= '0;
      half_stock_q <= '0;
      prefer_q     <= 1'b0;
      credit_q     <= '0;
      timer_q      <= '0;
      one_q        <= 1'b0;
      half_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      got_drink_q  <= 1'b0;
      got_change_q <= 1'b0;
      err_q        <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      one_stock_q  <= one_stock_d;
      half_stock_q <= half_stock_d;
      prefer_q     <= prefer_d;
      credit_q     <= credit_d;
      timer_q      <= timer_d;
      one_q        <= one_d;
      half_q       <= half_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      got_drink_q  <= got_drink_d;
      got_change_q <= got_change_d;
      err_q        <= err_d;
    end
  end

  assign one        = one_q;
  assign half       = half_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign got_drink  = got_drink_q;
  assign got_change = got_change_q;
  assign err        = err_q;

endmodule
